float_divider: RTL and testbench
================================

# float_divider

Multi-cycle IEEE-754 single-precision divider that computes fz = fa / fb as fa × (1/fb). It sequences the downstream `float_reciprocal` block for its fixed 8-step schedule and owns the FPU's shared adder and multiplier, arbitrating them between the reciprocal and its own final multiply. It handles IEEE special operands directly, without running the reciprocal. The FPU top level gives it a start/busy/done handshake.

## Interface
Parameters: none.

Ports:
- clk  in  1  system clock, rising edge
- clr  in  1  reset; asynchronous, active-high; also wired to `float_reciprocal`'s clr so both step counters clear together
- start  in  1  begin division; sampled only in IDLE
- fa  in  32  dividend, sampled on the accepting edge
- fb  in  32  divisor, sampled on the accepting edge
- fz  out  32  quotient register; holds until the next accepted start
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse when fz becomes valid
- frc_fa  out  32  operand to reciprocal; driven from the latched fb
- frc_en  out  1  reciprocal step-counter enable
- frc_fz  in  32  reciprocal result; valid during reciprocal step 7
- frc_fadd_a_in, frc_fadd_b_in, frc_fmul_a_in, frc_fmul_b_in  in  32  adder/multiplier operand requests from the reciprocal
- fadd_a_in, fadd_b_in, fmul_a_in, fmul_b_in  out  32  operands to the shared FPU adder and multiplier
- fmul_out  in  32  shared multiplier result

## Operation
- Internal registers: a_q, b_q (latched operands), r_q (reciprocal), fz, 2-bit state, 3-bit step counter cnt.
- States: IDLE, RECIP, MUL, DONE.
- IDLE with start=1:
  - latch a_q=fa, b_q=fb and classify.
  - Special case: load fz with the special result and go to DONE.
  - Otherwise: go to RECIP with cnt=0.
- RECIP:
  - frc_en=1 for exactly 8 cycles; cnt increments each cycle.
  - FPU operand outputs pass through the frc_* requests.
  - When cnt=7, latch r_q=frc_fz and go to MUL.
  - Exactly 8 enabled cycles keep the reciprocal's counter wrapping back to 0.
- MUL: fmul_a_in=a_q, fmul_b_in=r_q; latch fz=fmul_out; go to DONE.
- DONE: done=1 for one cycle, then return to IDLE.
- Outside RECIP: frc_en=0 and fadd_*_in=0. fmul_*_in=0 except in MUL.
- Operands with exponent 0 are treated as zero (denormals flushed). Special cases, checked in this priority order (s = sa XOR sb):
  1. Either operand NaN, 0/0, or inf/inf -> 0x7FC00000.
  2. fb zero -> {s, 0xFF, 0}, i.e. signed infinity.
  3. fa inf -> signed infinity.
  4. fb inf or fa zero -> {s, 31'b0}, i.e. signed zero.
- Overflow and underflow in the final multiply are passed through from fmul_out unchanged.
- start while busy is ignored; a_q and b_q stay unchanged.

## Timing
- Reset values: state=IDLE, cnt=0, fz=0, r_q=0, a_q=0, b_q=0, busy=0, done=0, frc_en=0.
- Normal latency, with start accepted at edge E0:
  - RECIP occupies the cycles after E0..E8, with r_q latched at E8.
  - MUL latches fz at E9.
  - done=1 during the cycle after E9, back in IDLE at E10.
- Special-case latency: fz loaded at E0, done=1 in the following cycle, IDLE at E1.
- Back-to-back: a start held high is accepted on the first edge in IDLE, i.e. E10 (normal) or E1 (special).
- clr mid-operation: immediate return to IDLE with all registers at reset values and no done pulse. The shared clr resets the reciprocal counter, so the next division is correctly aligned.
- Result accuracy is bounded by the reciprocal approximation plus one multiply; the bench tolerance is ≤2 ulp.

## Test plan
- 6.0/2.0 (0x40C00000 / 0x40000000) -> fz=0x40400000 ±2 ulp; done exactly 10 edges after the accepting edge; frc_en high for exactly 8 cycles.
- 1.0/0.0 -> 0x7F800000; -1.0/0.0 -> 0xFF800000; 0/0 -> 0x7FC00000; 5.0/inf -> 0x00000000; each with done one cycle after start and frc_en never asserted.
- start pulsed again mid-RECIP with different operands -> ignored; the first result completes unchanged.
- clr asserted at cnt=4, then a new 1.0/4.0 -> 0x3E800000 ±2 ulp; no stale done pulse.
- 1000 random normal pairs, exponents 100..150, random signs, back-to-back starts -> each within 2 ulp of the reference a/b; sign correct.
- -3.0/-1.5 -> 0x40000000 ±2 ulp; fz holds its value through the following IDLE cycles.

Source files
------------

// File: rtl/float_divider.sv
// Multi-cycle single-precision divider: fz = fa * (1/fb).
// Sequences the external reciprocal block and arbitrates the shared FPU adder/multiplier.
module float_divider (
  input  logic        clk,
  input  logic        clr,
  input  logic        start,
  input  logic [31:0] fa,
  input  logic [31:0] fb,
  output logic [31:0] fz,
  output logic        busy,
  output logic        done,
  output logic [31:0] frc_fa,
  output logic        frc_en,
  input  logic [31:0] frc_fz,
  input  logic [31:0] frc_fadd_a_in,
  input  logic [31:0] frc_fadd_b_in,
  input  logic [31:0] frc_fmul_a_in,
  input  logic [31:0] frc_fmul_b_in,
  output logic [31:0] fadd_a_in,
  output logic [31:0] fadd_b_in,
  output logic [31:0] fmul_a_in,
  output logic [31:0] fmul_b_in,
  input  logic [31:0] fmul_out
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RECIP = 2'd1,
    MUL   = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [31:0] r_q, r_d;
  logic [31:0] fz_q, fz_d;

  logic a_zero, a_inf, a_nan;
  logic b_zero, b_inf, b_nan;
  logic sgn, special;
  logic [31:0] spec_z;

  // Denormals (exponent 0) are flushed to zero.
  assign a_zero = fa[30:23] == 8'h00;
  assign a_inf  = fa[30:23] == 8'hFF && fa[22:0] == 23'd0;
  assign a_nan  = fa[30:23] == 8'hFF && fa[22:0] != 23'd0;
  assign b_zero = fb[30:23] == 8'h00;
  assign b_inf  = fb[30:23] == 8'hFF && fb[22:0] == 23'd0;
  assign b_nan  = fb[30:23] == 8'hFF && fb[22:0] != 23'd0;
  assign sgn    = fa[31] ^ fb[31];

  always_comb begin
    special = 1'b1;
    spec_z  = 32'h7FC00000;
    if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
      spec_z = 32'h7FC00000;
    end else if (b_zero || a_inf) begin
      spec_z = {sgn, 8'hFF, 23'd0};
    end else if (b_inf || a_zero) begin
      spec_z = {sgn, 31'd0};
    end else begin
      special = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q <= IDLE;
      cnt_q   <= 3'd0;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      r_q     <= 32'd0;
      fz_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      r_q     <= r_d;
      fz_q    <= fz_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    a_d       = a_q;
    b_d       = b_q;
    r_d       = r_q;
    fz_d      = fz_q;
    frc_en    = 1'b0;
    fadd_a_in = 32'd0;
    fadd_b_in = 32'd0;
    fmul_a_in = 32'd0;
    fmul_b_in = 32'd0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          a_d = fa;
          b_d = fb;
          if (special) begin
            fz_d    = spec_z;
            state_d = DONE;
          end else begin
            cnt_d   = 3'd0;
            state_d = RECIP;
          end
        end
      end
      RECIP: begin
        // Exactly 8 enables keep the reciprocal's own counter wrapping to 0.
        frc_en    = 1'b1;
        fadd_a_in = frc_fadd_a_in;
        fadd_b_in = frc_fadd_b_in;
        fmul_a_in = frc_fmul_a_in;
        fmul_b_in = frc_fmul_b_in;
        cnt_d     = cnt_q + 3'd1;
        if (cnt_q == 3'd7) begin
          r_d     = frc_fz;
          state_d = MUL;
        end
      end
      MUL: begin
        fmul_a_in = a_q;
        fmul_b_in = r_q;
        fz_d      = fmul_out;
        state_d   = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign fz     = fz_q;
  assign busy   = state_q != IDLE;
  assign done   = state_q == DONE;
  assign frc_fa = b_q;

endmodule

// File: tb/tb_float_divider.sv
// Directed and random checks for float_divider.
// Models the reciprocal block and the shared multiplier with real arithmetic.
module tb_float_divider;

  logic        clk = 1'b0;
  logic        clr, start;
  logic [31:0] fa, fb, fz, frc_fa, frc_fz;
  logic        busy, done, frc_en;
  logic [31:0] frc_fadd_a_in, frc_fadd_b_in;
  logic [31:0] frc_fmul_a_in, frc_fmul_b_in;
  logic [31:0] fadd_a_in, fadd_b_in;
  logic [31:0] fmul_a_in, fmul_b_in, fmul_out;
  logic [2:0]  rc_q;
  int          n_chk = 0;
  int          n_err = 0;

  float_divider dut (
    .clk(clk), .clr(clr), .start(start),
    .fa(fa), .fb(fb), .fz(fz),
    .busy(busy), .done(done),
    .frc_fa(frc_fa), .frc_en(frc_en), .frc_fz(frc_fz),
    .frc_fadd_a_in(frc_fadd_a_in), .frc_fadd_b_in(frc_fadd_b_in),
    .frc_fmul_a_in(frc_fmul_a_in), .frc_fmul_b_in(frc_fmul_b_in),
    .fadd_a_in(fadd_a_in), .fadd_b_in(fadd_b_in),
    .fmul_a_in(fmul_a_in), .fmul_b_in(fmul_b_in),
    .fmul_out(fmul_out)
  );

  always #5 clk = ~clk;

  function automatic real f2r(input logic [31:0] f);
    logic [63:0] d;
    if (f[30:23] == 8'h00) return 0.0;
    d = {f[31], 11'(int'(f[30:23]) - 127 + 1023), f[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] r2f(input real x);
    logic [63:0] d;
    logic [24:0] m;
    int e;
    if (x == 0.0) return 32'd0;
    d = $realtobits(x);
    e = int'(d[62:52]) - 1023 + 127;
    m = {2'b01, d[51:29]} + {24'd0, d[28]};
    if (m[24]) begin
      e = e + 1;
      return {d[63], 8'(e), m[23:1]};
    end
    return {d[63], 8'(e), m[22:0]};
  endfunction

  always @(posedge clk or posedge clr)
    if (clr) rc_q <= 3'd0;
    else if (frc_en) rc_q <= rc_q + 3'd1;

  always_comb begin
    frc_fz = 32'd0;
    if (rc_q == 3'd7) frc_fz = r2f(1.0 / f2r(frc_fa));
    fmul_out = r2f(f2r(fmul_a_in) * f2r(fmul_b_in));
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp, input int tol);
    longint d;
    n_chk++;
    d = longint'({32'd0, obs}) - longint'({32'd0, exp});
    if (d < 0) d = -d;
    if (d > longint'(tol)) begin
      n_err++;
      $display("FAIL %s: got %h want %h (tol %0d)", tag, obs, exp, tol);
    end
  endtask

  task automatic do_div(input string tag, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] ez,
                        input int tol, input int elat, input int een,
                        input bit mid);
    int lat, en;
    lat = 0;
    en = 0;
    @(negedge clk);
    fa = a;
    fb = b;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (mid && i == 3) begin
        fa = 32'h3F800000;
        fb = 32'h40800000;
        start = 1'b1;
      end else if (mid && i == 4) begin
        start = 1'b0;
      end
      if (i == 2 && frc_en) begin
        chk({tag, "_padd"}, fadd_a_in, frc_fadd_a_in, 0);
        chk({tag, "_pmul"}, fmul_b_in, frc_fmul_b_in, 0);
      end
      if (frc_en) en++;
      if (done) begin
        lat = i + 1;
        break;
      end
    end
    start = 1'b0;
    chk({tag, "_lat"}, lat, elat, 0);
    chk({tag, "_en"}, en, een, 0);
    chk({tag, "_fz"}, fz, ez, tol);
    @(negedge clk);
    chk({tag, "_idle"}, {busy, done, frc_en, fadd_a_in[28:0]}, 32'd0, 0);
  endtask

  initial begin
    logic [31:0] ra, rb, rz;
    int dcnt, wait_n;
    bit ok;
    clr = 1'b1;
    start = 1'b0;
    fa = 32'd0;
    fb = 32'd0;
    frc_fadd_a_in = 32'h11111111;
    frc_fadd_b_in = 32'h33333333;
    frc_fmul_a_in = 32'h22222222;
    frc_fmul_b_in = 32'h44444444;
    repeat (2) @(negedge clk);
    chk("rst_fz", fz, 32'd0, 0);
    chk("rst_ctl", {busy, done, frc_en}, 32'd0, 0);
    chk("rst_fra", frc_fa, 32'd0, 0);
    clr = 1'b0;

    do_div("d6_2", 32'h40C00000, 32'h40000000, 32'h40400000, 2, 10, 8, 0);
    do_div("p1_0", 32'h3F800000, 32'h00000000, 32'h7F800000, 0, 1, 0, 0);
    do_div("m1_0", 32'hBF800000, 32'h00000000, 32'hFF800000, 0, 1, 0, 0);
    do_div("z_z", 32'h00000000, 32'h00000000, 32'h7FC00000, 0, 1, 0, 0);
    do_div("f_inf", 32'h40A00000, 32'h7F800000, 32'h00000000, 0, 1, 0, 0);
    do_div("nan", 32'h7FC00001, 32'h3F800000, 32'h7FC00000, 0, 1, 0, 0);
    do_div("ii", 32'hFF800000, 32'h7F800000, 32'h7FC00000, 0, 1, 0, 0);
    do_div("inf_m2", 32'h7F800000, 32'hC0000000, 32'hFF800000, 0, 1, 0, 0);
    do_div("z_m3", 32'h00000000, 32'hC0400000, 32'h80000000, 0, 1, 0, 0);
    do_div("dnrm", 32'h3F800000, 32'h00000001, 32'h7F800000, 0, 1, 0, 0);
    do_div("mid", 32'h40C00000, 32'h40000000, 32'h40400000, 2, 10, 8, 1);

    @(negedge clk);
    fa = 32'h40C00000;
    fb = 32'h40000000;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    clr = 1'b1;
    #1;
    chk("clr_fz", fz, 32'd0, 0);
    chk("clr_ctl", {busy, done, frc_en}, 32'd0, 0);
    @(negedge clk);
    clr = 1'b0;
    dcnt = 0;
    repeat (12) begin
      @(negedge clk);
      if (done) dcnt++;
    end
    chk("clr_stale", dcnt, 0, 0);
    do_div("q1_4", 32'h3F800000, 32'h40800000, 32'h3E800000, 2, 10, 8, 0);
    do_div("m3_m15", 32'hC0400000, 32'hBFC00000, 32'h40000000, 2, 10, 8, 0);
    repeat (3) @(negedge clk);
    chk("hold", fz, 32'h40000000, 2);

    ok = 1'b1;
    @(negedge clk);
    ra = {1'($urandom), 8'($urandom_range(150, 100)), 23'($urandom)};
    rb = {1'($urandom), 8'($urandom_range(150, 100)), 23'($urandom)};
    rz = r2f(f2r(ra) / f2r(rb));
    fa = ra;
    fb = rb;
    start = 1'b1;
    for (int k = 0; k < 1000 && ok; k++) begin
      wait_n = 0;
      do begin
        @(negedge clk);
        wait_n++;
      end while (!done && wait_n < 30);
      if (!done) begin
        chk("rnd_tmo", 32'd0, 32'd1, 0);
        ok = 1'b0;
      end else begin
        chk("rnd", fz, rz, 2);
        ra = {1'($urandom), 8'($urandom_range(150, 100)), 23'($urandom)};
        rb = {1'($urandom), 8'($urandom_range(150, 100)), 23'($urandom)};
        rz = r2f(f2r(ra) / f2r(rb));
        fa = ra;
        fb = rb;
        if (k == 999) start = 1'b0;
      end
    end
    start = 1'b0;
    repeat (15) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
